branch_target_buffer: RTL and testbench
=======================================

# branch_target_buffer

- Parametrised branch target buffer (BTB) with saturating-counter direction prediction for the 5-stage pipeline.
- Sits beside the IF-stage PC register. It supplies a predicted next PC combinationally from `PC_F`.
- It is trained from ID, where beq/bne/j resolve. This replaces the fixed predict-not-taken-and-flush policy.
- It also maintains branch and mispredict statistics counters for performance measurement.

## Interface
Parameters:
- `ENTRIES`, 16: number of table entries; power of two, ≥2. `IDX_W = log2(ENTRIES)`.
- `PC_W`, 32: PC width. Tag width is `TAG_W = PC_W - IDX_W - 2`.
- `CTR_W`, 2: direction counter width, ≥1.
- `STAT_W`, 32: statistics counter width.

Ports (name, direction, width, meaning):
- `CLOCK`, in, 1: single clock; all state updates on the rising edge.
- `RESET`, in, 1: asynchronous, active-high reset.
- `PC_F`, in, `PC_W`: fetch PC to look up.
- `Hit_F`, out, 1: a valid entry matches `PC_F`.
- `PredTaken_F`, out, 1: equals `Hit_F & ctr[CTR_W-1]`.
- `PredTarget_F`, out, `PC_W`: stored target on hit; 0 otherwise.
- `UpdateEN_D`, in, 1: a control-transfer instruction resolved in ID this cycle; the pipeline holds it low during `Stall`.
- `UpdatePC_D`, in, `PC_W`: PC of the resolved instruction.
- `UpdateTaken_D`, in, 1: actual outcome.
- `UpdateTarget_D`, in, `PC_W`: actual target; meaningful only when taken.
- `PredTaken_D`, in, 1: prediction made in IF, piped through IF/ID.
- `PredTarget_D`, in, `PC_W`: prediction target made in IF, piped through IF/ID.
- `Mispredict_D`, out, 1: combinational, `UpdateEN_D & ((UpdateTaken_D != PredTaken_D) | (UpdateTaken_D & UpdateTarget_D != PredTarget_D))`.
- `Invalidate`, in, 1: synchronous clear of all valid bits.
- `BranchCount`, out, `STAT_W`: number of updates.
- `MispredCount`, out, `STAT_W`: number of mispredicts.

## Operation
Addressing:
- Index is `PC[IDX_W+1:2]`; tag is `PC[PC_W-1:IDX_W+2]`.
- Each entry holds `valid`, `tag`, `target`, and `ctr`.

Lookup (purely combinational):
- Hit when `valid[idx] & tag[idx]==tag(PC_F)`.

Update on a rising edge with `UpdateEN_D=1` and `Invalidate=0`:
- **Entry hits on `UpdatePC_D`:**
  - `ctr` saturating-increments if taken, otherwise saturating-decrements.
  - If taken, `target` is overwritten with `UpdateTarget_D`.
- **Miss and taken:** allocate the entry (overwrite, direct-mapped):
  - `valid=1`, `tag` = tag of `UpdatePC_D`, `target=UpdateTarget_D`.
  - `ctr = 1<<(CTR_W-1)` (weakly taken).
- **Miss and not taken:** no table change.
- **Statistics:**
  - `BranchCount` increments by 1 per update.
  - `MispredCount` increments when `Mispredict_D=1`.
  - Both saturate at all-ones; they never wrap.

Invalidate:
- Clears every `valid` bit. `tag`, `target` and `ctr` are not cleared.
- Statistics are unaffected.
- If asserted together with an update, Invalidate wins: no table write.
- The statistics still count that update.

Reset (asynchronous, takes effect immediately):
- All `valid=0`.
- All `ctr = (1<<(CTR_W-1))-1` (weakly not-taken).
- `target` and `tag` are cleared to 0.
- Both statistics counters are cleared to 0.
- While RESET is high: `Hit_F=0`, `PredTaken_F=0`, `PredTarget_F=0`.
- `Mispredict_D` remains combinational from its inputs.

## Timing
- Lookup latency is 0 cycles (same-cycle combinational from `PC_F`). Update latency is 1 cycle.
- A lookup in the same cycle as an update to the same index returns the pre-update contents. The new contents are visible from the next cycle.
- No read-during-write bypass.
- `Mispredict_D` is valid in the same cycle as `UpdateEN_D`. The CPU uses it to redirect the PC and flush IF/ID on the following edge.
- RESET deasserting mid-sequence: the first edge after deassertion processes inputs normally.
- Aliasing: two PCs with the same index and different tags evict each other. No stale hit is permitted because the tag must match.
- With `CTR_W=1`, the counter is a single taken bit. Allocation sets it to 1; reset sets it to 0.

## Test plan
Defaults apply (`ENTRIES=16`, `CTR_W=2`).

1. **Reset and lookup:**
   - Stimulus: assert RESET, then deassert; set `PC_F=0x40`.
   - Required: `Hit_F=0`, `PredTaken_F=0`, `PredTarget_F=0`, `BranchCount=0`, `MispredCount=0`.
2. **Allocate and predict:**
   - Stimulus: update `PC=0x40`, taken, target `0x100`, `PredTaken_D=0`.
   - Required: `Mispredict_D=1`. Next cycle, `PC_F=0x40` gives `Hit_F=1`, `PredTaken_F=1`, `PredTarget_F=0x100`. `MispredCount=1`.
3. **Counter saturation and decay:**
   - Stimulus: from step 2, apply 3 taken updates, then 2 not-taken updates.
   - Required: ctr saturates at 3; after 1 not-taken it is 2 (still predicts taken); after the 2nd it is 1, so `PredTaken_F=0` with `Hit_F=1`.
4. **Alias eviction:**
   - Stimulus: allocate `0x40`, then taken update of `0x80` (same index 0) with target `0x200`.
   - Required: lookup `0x40` misses; lookup `0x80` hits with `PredTarget_F=0x200`.
5. **Simultaneous events:**
   - Stimulus: `Invalidate` and a taken update in the same cycle; separately, update and lookup of the same index in one cycle.
   - Required: after the invalidate, all lookups miss and `BranchCount` has still incremented. For update plus lookup, the lookup shows the old value that cycle and the new value the next cycle.
6. **Statistics saturation:**
   - Stimulus: set `STAT_W=4`; issue 20 mispredicted updates.
   - Required: `BranchCount=15`, `MispredCount=15`. Async RESET mid-burst zeroes both immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/branch_target_buffer.sv
// branch_target_buffer: direct-mapped BTB with saturating direction counters and branch statistics
module branch_target_buffer #(
  parameter int ENTRIES = 16,
  parameter int PC_W = 32,
  parameter int CTR_W = 2,
  parameter int STAT_W = 32
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic [PC_W-1:0]   PC_F,
  output logic              Hit_F,
  output logic              PredTaken_F,
  output logic [PC_W-1:0]   PredTarget_F,
  input  logic              UpdateEN_D,
  input  logic [PC_W-1:0]   UpdatePC_D,
  input  logic              UpdateTaken_D,
  input  logic [PC_W-1:0]   UpdateTarget_D,
  input  logic              PredTaken_D,
  input  logic [PC_W-1:0]   PredTarget_D,
  output logic              Mispredict_D,
  input  logic              Invalidate,
  output logic [STAT_W-1:0] BranchCount,
  output logic [STAT_W-1:0] MispredCount
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 2;
  localparam logic [CTR_W-1:0] CTR_MAX = '1;
  localparam logic [CTR_W-1:0] CTR_WT = CTR_W'(1 << (CTR_W - 1));
  localparam logic [CTR_W-1:0] CTR_WN = CTR_W'((1 << (CTR_W - 1)) - 1);
  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0]   tags [ENTRIES];
  logic [PC_W-1:0]    targets [ENTRIES];
  logic [CTR_W-1:0]   ctrs [ENTRIES];
  logic [IDX_W-1:0]   f_idx, u_idx;
  logic [TAG_W-1:0]   f_tag, u_tag;
  logic               u_hit;
  logic [CTR_W-1:0]   u_ctr;
  logic               unused_lsbs;
  assign f_idx = PC_F[IDX_W+1:2];
  assign f_tag = PC_F[PC_W-1:IDX_W+2];
  assign u_idx = UpdatePC_D[IDX_W+1:2];
  assign u_tag = UpdatePC_D[PC_W-1:IDX_W+2];
  assign unused_lsbs = ^{PC_F[1:0], UpdatePC_D[1:0]};
  // lookup is gated by RESET so outputs are quiet for the whole reset pulse
  assign Hit_F = !RESET && valid[f_idx] && tags[f_idx] == f_tag;
  assign PredTaken_F = Hit_F && ctrs[f_idx][CTR_W-1];
  assign PredTarget_F = Hit_F ? targets[f_idx] : '0;
  assign u_hit = valid[u_idx] && tags[u_idx] == u_tag;
  assign u_ctr = UpdateTaken_D ? ((ctrs[u_idx] == CTR_MAX) ? CTR_MAX : ctrs[u_idx] + CTR_W'(1))
                               : ((ctrs[u_idx] == '0) ? '0 : ctrs[u_idx] - CTR_W'(1));
  assign Mispredict_D = UpdateEN_D && ((UpdateTaken_D != PredTaken_D) ||
                                       (UpdateTaken_D && UpdateTarget_D != PredTarget_D));
  // table: invalidate beats any write; misses only allocate when taken
  always_ff @(posedge CLOCK or posedge RESET)
    if (RESET) begin
      valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tags[i] <= '0;
        targets[i] <= '0;
        ctrs[i] <= CTR_WN;
      end
    end else if (Invalidate) valid <= '0;
    else if (UpdateEN_D && (u_hit || UpdateTaken_D)) begin
      valid[u_idx] <= 1'b1;
      tags[u_idx] <= u_tag;
      ctrs[u_idx] <= u_hit ? u_ctr : CTR_WT;
      if (UpdateTaken_D) targets[u_idx] <= UpdateTarget_D;
    end
  // statistics saturate at all-ones and ignore Invalidate
  always_ff @(posedge CLOCK or posedge RESET)
    if (RESET) begin
      BranchCount <= '0;
      MispredCount <= '0;
    end else begin
      if (UpdateEN_D && !(&BranchCount)) BranchCount <= BranchCount + STAT_W'(1);
      if (Mispredict_D && !(&MispredCount)) MispredCount <= MispredCount + STAT_W'(1);
    end
endmodule

// File: tb/tb_branch_target_buffer.sv
// tb_branch_target_buffer: directed self-checking bench for branch_target_buffer
module tb_branch_target_buffer;
  logic        CLOCK = 1'b0;
  logic        RESET, UpdateEN_D, UpdateTaken_D, PredTaken_D, Invalidate;
  logic [31:0] PC_F, UpdatePC_D, UpdateTarget_D, PredTarget_D;
  logic        Hit_F, PredTaken_F, Mispredict_D;
  logic [31:0] PredTarget_F, BranchCount, MispredCount;
  logic        s_RESET, s_UpdateEN_D, s_Hit_F, s_PredTaken_F, s_Mispredict_D;
  logic [31:0] s_PredTarget_F;
  logic [3:0]  s_BranchCount, s_MispredCount;
  int checks = 0;
  int errors = 0;
  always #5 CLOCK = ~CLOCK;
  branch_target_buffer dut (
    .CLOCK(CLOCK), .RESET(RESET), .PC_F(PC_F), .Hit_F(Hit_F), .PredTaken_F(PredTaken_F),
    .PredTarget_F(PredTarget_F), .UpdateEN_D(UpdateEN_D), .UpdatePC_D(UpdatePC_D),
    .UpdateTaken_D(UpdateTaken_D), .UpdateTarget_D(UpdateTarget_D), .PredTaken_D(PredTaken_D),
    .PredTarget_D(PredTarget_D), .Mispredict_D(Mispredict_D), .Invalidate(Invalidate),
    .BranchCount(BranchCount), .MispredCount(MispredCount)
  );
  branch_target_buffer #(.STAT_W(4)) sdut (
    .CLOCK(CLOCK), .RESET(s_RESET), .PC_F(32'h40), .Hit_F(s_Hit_F), .PredTaken_F(s_PredTaken_F),
    .PredTarget_F(s_PredTarget_F), .UpdateEN_D(s_UpdateEN_D), .UpdatePC_D(32'h40),
    .UpdateTaken_D(1'b1), .UpdateTarget_D(32'h100), .PredTaken_D(1'b0),
    .PredTarget_D(32'h0), .Mispredict_D(s_Mispredict_D), .Invalidate(1'b0),
    .BranchCount(s_BranchCount), .MispredCount(s_MispredCount)
  );
  task automatic set_upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                         input logic pt, input logic [31:0] ptgt);
    UpdateEN_D = 1'b1; UpdatePC_D = pc; UpdateTaken_D = tk; UpdateTarget_D = tgt;
    PredTaken_D = pt; PredTarget_D = ptgt;
  endtask
  task automatic clk_upd;
    @(posedge CLOCK);
    #1 UpdateEN_D = 1'b0; Invalidate = 1'b0;
    #1;
  endtask
  task automatic test_reset;
    PC_F = 32'h40;
    repeat (2) @(posedge CLOCK);
    #1;
    checks++; if (Hit_F !== 1'b0) begin errors++; $display("FAIL reset_hold_hit got %b exp 0", Hit_F); end
    RESET = 1'b0; s_RESET = 1'b0;
    #1;
    checks++; if (Hit_F !== 1'b0) begin errors++; $display("FAIL reset_hit got %b exp 0", Hit_F); end
    checks++; if (PredTaken_F !== 1'b0) begin errors++; $display("FAIL reset_pt got %b exp 0", PredTaken_F); end
    checks++; if (PredTarget_F !== 32'h0) begin errors++; $display("FAIL reset_tgt got %h exp 0", PredTarget_F); end
    checks++; if (BranchCount !== 32'd0) begin errors++; $display("FAIL reset_bc got %0d exp 0", BranchCount); end
    checks++; if (MispredCount !== 32'd0) begin errors++; $display("FAIL reset_mc got %0d exp 0", MispredCount); end
  endtask
  task automatic test_mispredict_comb;
    set_upd(32'h40, 1'b1, 32'h100, 1'b1, 32'h104);
    #1;
    checks++; if (Mispredict_D !== 1'b1) begin errors++; $display("FAIL misp_target got %b exp 1", Mispredict_D); end
    PredTarget_D = 32'h100;
    #1;
    checks++; if (Mispredict_D !== 1'b0) begin errors++; $display("FAIL misp_correct got %b exp 0", Mispredict_D); end
    UpdateTaken_D = 1'b0; PredTaken_D = 1'b0; UpdateTarget_D = 32'h999;
    #1;
    checks++; if (Mispredict_D !== 1'b0) begin errors++; $display("FAIL misp_nt_ignore_tgt got %b exp 0", Mispredict_D); end
    PredTaken_D = 1'b1;
    UpdateEN_D = 1'b0;
    #1;
    checks++; if (Mispredict_D !== 1'b0) begin errors++; $display("FAIL misp_no_en got %b exp 0", Mispredict_D); end
  endtask
  task automatic test_allocate;
    set_upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h0);
    #1;
    checks++; if (Mispredict_D !== 1'b1) begin errors++; $display("FAIL alloc_misp got %b exp 1", Mispredict_D); end
    checks++; if (Hit_F !== 1'b0) begin errors++; $display("FAIL alloc_pre_hit got %b exp 0", Hit_F); end
    clk_upd;
    checks++; if (Hit_F !== 1'b1) begin errors++; $display("FAIL alloc_hit got %b exp 1", Hit_F); end
    checks++; if (PredTaken_F !== 1'b1) begin errors++; $display("FAIL alloc_pt got %b exp 1", PredTaken_F); end
    checks++; if (PredTarget_F !== 32'h100) begin errors++; $display("FAIL alloc_tgt got %h exp 100", PredTarget_F); end
    checks++; if (MispredCount !== 32'd1) begin errors++; $display("FAIL alloc_mc got %0d exp 1", MispredCount); end
    checks++; if (BranchCount !== 32'd1) begin errors++; $display("FAIL alloc_bc got %0d exp 1", BranchCount); end
  endtask
  task automatic test_counter;
    for (int i = 0; i < 3; i++) begin
      set_upd(32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
      clk_upd;
    end
    checks++; if (PredTaken_F !== 1'b1) begin errors++; $display("FAIL ctr_sat_pt got %b exp 1", PredTaken_F); end
    set_upd(32'h40, 1'b0, 32'h0, 1'b1, 32'h100);
    clk_upd;
    checks++; if (Hit_F !== 1'b1) begin errors++; $display("FAIL ctr_dec1_hit got %b exp 1", Hit_F); end
    checks++; if (PredTaken_F !== 1'b1) begin errors++; $display("FAIL ctr_dec1_pt got %b exp 1", PredTaken_F); end
    set_upd(32'h40, 1'b0, 32'h0, 1'b1, 32'h100);
    clk_upd;
    checks++; if (Hit_F !== 1'b1) begin errors++; $display("FAIL ctr_dec2_hit got %b exp 1", Hit_F); end
    checks++; if (PredTaken_F !== 1'b0) begin errors++; $display("FAIL ctr_dec2_pt got %b exp 0", PredTaken_F); end
    checks++; if (PredTarget_F !== 32'h100) begin errors++; $display("FAIL ctr_nt_keep_tgt got %h exp 100", PredTarget_F); end
    checks++; if (BranchCount !== 32'd6) begin errors++; $display("FAIL ctr_bc got %0d exp 6", BranchCount); end
    checks++; if (MispredCount !== 32'd3) begin errors++; $display("FAIL ctr_mc got %0d exp 3", MispredCount); end
  endtask
  task automatic test_alias;
    set_upd(32'h80, 1'b1, 32'h200, 1'b0, 32'h0);
    clk_upd;
    checks++; if (Hit_F !== 1'b0) begin errors++; $display("FAIL alias_old_hit got %b exp 0", Hit_F); end
    PC_F = 32'h80;
    #1;
    checks++; if (Hit_F !== 1'b1) begin errors++; $display("FAIL alias_new_hit got %b exp 1", Hit_F); end
    checks++; if (PredTarget_F !== 32'h200) begin errors++; $display("FAIL alias_tgt got %h exp 200", PredTarget_F); end
    checks++; if (PredTaken_F !== 1'b1) begin errors++; $display("FAIL alias_pt got %b exp 1", PredTaken_F); end
  endtask
  task automatic test_invalidate;
    set_upd(32'h44, 1'b1, 32'h300, 1'b0, 32'h0);
    Invalidate = 1'b1;
    clk_upd;
    checks++; if (Hit_F !== 1'b0) begin errors++; $display("FAIL inv_hit_80 got %b exp 0", Hit_F); end
    PC_F = 32'h44;
    #1;
    checks++; if (Hit_F !== 1'b0) begin errors++; $display("FAIL inv_hit_44 got %b exp 0", Hit_F); end
    checks++; if (BranchCount !== 32'd8) begin errors++; $display("FAIL inv_bc got %0d exp 8", BranchCount); end
    checks++; if (MispredCount !== 32'd5) begin errors++; $display("FAIL inv_mc got %0d exp 5", MispredCount); end
  endtask
  task automatic test_same_cycle;
    PC_F = 32'h48;
    set_upd(32'h48, 1'b1, 32'h400, 1'b0, 32'h0);
    #1;
    checks++; if (Hit_F !== 1'b0) begin errors++; $display("FAIL rdw_alloc_old got %b exp 0", Hit_F); end
    clk_upd;
    checks++; if (PredTarget_F !== 32'h400) begin errors++; $display("FAIL rdw_alloc_new got %h exp 400", PredTarget_F); end
    set_upd(32'h48, 1'b1, 32'h500, 1'b1, 32'h400);
    #1;
    checks++; if (PredTarget_F !== 32'h400) begin errors++; $display("FAIL rdw_upd_old got %h exp 400", PredTarget_F); end
    clk_upd;
    checks++; if (PredTarget_F !== 32'h500) begin errors++; $display("FAIL rdw_upd_new got %h exp 500", PredTarget_F); end
    checks++; if (MispredCount !== 32'd7) begin errors++; $display("FAIL rdw_mc got %0d exp 7", MispredCount); end
  endtask
  task automatic test_miss_not_taken;
    PC_F = 32'h4C;
    set_upd(32'h4C, 1'b0, 32'h700, 1'b0, 32'h0);
    clk_upd;
    checks++; if (Hit_F !== 1'b0) begin errors++; $display("FAIL miss_nt_hit got %b exp 0", Hit_F); end
    checks++; if (BranchCount !== 32'd11) begin errors++; $display("FAIL miss_nt_bc got %0d exp 11", BranchCount); end
    checks++; if (MispredCount !== 32'd7) begin errors++; $display("FAIL miss_nt_mc got %0d exp 7", MispredCount); end
  endtask
  task automatic test_async_reset;
    PC_F = 32'h48;
    #1;
    checks++; if (Hit_F !== 1'b1) begin errors++; $display("FAIL ares_pre_hit got %b exp 1", Hit_F); end
    RESET = 1'b1;
    #1;
    checks++; if (Hit_F !== 1'b0) begin errors++; $display("FAIL ares_hit got %b exp 0", Hit_F); end
    checks++; if (BranchCount !== 32'd0) begin errors++; $display("FAIL ares_bc got %0d exp 0", BranchCount); end
    checks++; if (MispredCount !== 32'd0) begin errors++; $display("FAIL ares_mc got %0d exp 0", MispredCount); end
    RESET = 1'b0;
    set_upd(32'h48, 1'b1, 32'h600, 1'b0, 32'h0);
    clk_upd;
    checks++; if (PredTarget_F !== 32'h600) begin errors++; $display("FAIL ares_first_edge got %h exp 600", PredTarget_F); end
    checks++; if (BranchCount !== 32'd1) begin errors++; $display("FAIL ares_first_bc got %0d exp 1", BranchCount); end
  endtask
  task automatic test_stat_sat;
    s_UpdateEN_D = 1'b1;
    repeat (20) @(posedge CLOCK);
    #1;
    checks++; if (s_BranchCount !== 4'd15) begin errors++; $display("FAIL sat_bc got %0d exp 15", s_BranchCount); end
    checks++; if (s_MispredCount !== 4'd15) begin errors++; $display("FAIL sat_mc got %0d exp 15", s_MispredCount); end
    checks++; if (s_Hit_F !== 1'b1) begin errors++; $display("FAIL sat_hit got %b exp 1", s_Hit_F); end
    s_RESET = 1'b1;
    #2;
    checks++; if (s_BranchCount !== 4'd0) begin errors++; $display("FAIL sat_ares_bc got %0d exp 0", s_BranchCount); end
    checks++; if (s_MispredCount !== 4'd0) begin errors++; $display("FAIL sat_ares_mc got %0d exp 0", s_MispredCount); end
    checks++; if (s_Hit_F !== 1'b0) begin errors++; $display("FAIL sat_ares_hit got %b exp 0", s_Hit_F); end
    s_UpdateEN_D = 1'b0;
    s_RESET = 1'b0;
  endtask
  initial begin
    RESET = 1'b1; s_RESET = 1'b1; s_UpdateEN_D = 1'b0;
    UpdateEN_D = 1'b0; UpdateTaken_D = 1'b0; PredTaken_D = 1'b0; Invalidate = 1'b0;
    PC_F = '0; UpdatePC_D = '0; UpdateTarget_D = '0; PredTarget_D = '0;
    test_reset;
    test_mispredict_comb;
    test_allocate;
    test_counter;
    test_alias;
    test_invalidate;
    test_same_cycle;
    test_miss_not_taken;
    test_async_reset;
    test_stat_sat;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
